// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel sink: coordinates, framebuffer addressing,
// queued plot commands and the sink FSM state.
package vga_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned FB_DEPTH = SCREEN_W * SCREEN_H;

    typedef logic [2:0]  colour_t;
    typedef logic [7:0]  xcoord_t;
    typedef logic [6:0]  ycoord_t;
    typedef logic [14:0] fbaddr_t;

    typedef struct packed {
        xcoord_t x;
        ycoord_t y;
        colour_t colour;
    } pixel_cmd_t;

    typedef enum logic {
        RUN,
        CLEAR
    } sink_state_t;

    // y*160 + x as y*128 + y*32 + x, avoiding a multiplier.
    function automatic fbaddr_t fb_addr(input xcoord_t x, input ycoord_t y);
        return fbaddr_t'({y, 7'd0}) + fbaddr_t'({y, 5'd0}) + fbaddr_t'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous show-ahead FIFO of plot commands; head entry is visible on pop_data_o
// whenever empty_o is low.
module plot_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  pixel_cmd_t push_data_i,
    input  logic       pop_i,
    output pixel_cmd_t pop_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    pixel_cmd_t mem_q [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    logic       do_push, do_pop;

    assign full_o     = (count_q == cnt_t'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        count_d  = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// Pixel sink for the VGA plot interface: bounds-checks and queues plots, commits them to a
// framebuffer RAM, and offers a registered readback port plus a whole-screen clear engine.
module vga_pixel_sink #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    output logic        plot_ready,
    input  logic        clear_start,
    output logic        clear_busy,
    input  logic        rd_en,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic [2:0]  rd_colour,
    output logic        rd_valid,
    output logic [15:0] plot_count,
    output logic [7:0]  drop_count,
    output logic [7:0]  oob_count
);

    import vga_pkg::*;

    localparam int unsigned FbDepth = SCREEN_W * SCREEN_H;
    localparam fbaddr_t     ClrLast = fbaddr_t'(FbDepth - 1);

    function automatic fbaddr_t addr_of(input xcoord_t x, input ycoord_t y);
        if (SCREEN_W == 160) begin
            return fb_addr(x, y);
        end
        return fbaddr_t'(32'(y) * SCREEN_W + 32'(x));
    endfunction

    function automatic logic in_bounds(input xcoord_t x, input ycoord_t y);
        return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
    endfunction

    sink_state_t state_q, state_d;
    fbaddr_t     clr_addr_q, clr_addr_d;
    logic [15:0] plot_cnt_q, plot_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [7:0]  oob_cnt_q, oob_cnt_d;
    logic        rd_valid_q, rd_valid_d;
    colour_t     rd_colour_q, rd_colour_d;

    colour_t     fb_mem [FbDepth];
    logic        fb_we;
    fbaddr_t     fb_waddr;
    colour_t     fb_wdata;

    pixel_cmd_t  fifo_in, fifo_head;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic        plot_oob, plot_drop;

    plot_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_plot_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_data_i(fifo_in),
        .pop_i      (fifo_pop),
        .pop_data_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Out-of-bounds plots are rejected before fullness is considered.
    always_comb begin
        plot_oob  = !in_bounds(vga_x, vga_y);
        plot_drop = vga_plot && !plot_oob && fifo_full;
        fifo_push = vga_plot && !plot_oob && !fifo_full;
        fifo_in   = '{x: vga_x, y: vga_y, colour: vga_colour};
        fifo_pop  = (state_q == RUN) && !fifo_empty;

        plot_cnt_d = (fifo_pop && plot_cnt_q != '1) ? plot_cnt_q + 16'd1 : plot_cnt_q;
        drop_cnt_d = (plot_drop && drop_cnt_q != '1) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        oob_cnt_d  = (vga_plot && plot_oob && oob_cnt_q != '1) ? oob_cnt_q + 8'd1 : oob_cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        fb_we      = 1'b0;
        fb_waddr   = addr_of(fifo_head.x, fifo_head.y);
        fb_wdata   = fifo_head.colour;
        unique case (state_q)
            RUN: begin
                fb_we = fifo_pop;
                if (clear_start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                fb_we      = 1'b1;
                fb_waddr   = clr_addr_q;
                fb_wdata   = '0;
                clr_addr_d = clr_addr_q + fbaddr_t'(1);
                if (clr_addr_q == ClrLast) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Readback samples the RAM before this edge's write lands (read-before-write).
    always_comb begin
        rd_valid_d  = rd_en;
        rd_colour_d = '0;
        if (rd_en && in_bounds(rd_x, rd_y)) begin
            rd_colour_d = fb_mem[addr_of(rd_x, rd_y)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            clr_addr_q  <= '0;
            plot_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            oob_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_colour_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            plot_cnt_q  <= plot_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            oob_cnt_q   <= oob_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_colour_q <= rd_colour_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fb_we) begin
            fb_mem[fb_waddr] <= fb_wdata;
        end
    end

    assign plot_ready = !fifo_full;
    assign clear_busy = (state_q == CLEAR);
    assign rd_colour  = rd_colour_q;
    assign rd_valid   = rd_valid_q;
    assign plot_count = plot_cnt_q;
    assign drop_count = drop_cnt_q;
    assign oob_count  = oob_cnt_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: directed reset/clear/readback sequences, a vector table of
// single plots, and a long randomized run against a queue-based reference model.
module tb_vga_pixel_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        plot_ready;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_x = '0;
    logic [6:0]  rd_y = '0;
    logic [2:0]  rd_colour;
    logic        rd_valid;
    logic [15:0] plot_count;
    logic [7:0]  drop_count;
    logic [7:0]  oob_count;

    always #5 clk = ~clk;

    vga_pixel_sink #(
        .FIFO_DEPTH(8),
        .SCREEN_W  (160),
        .SCREEN_H  (120)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .plot_ready (plot_ready),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_colour  (rd_colour),
        .rd_valid   (rd_valid),
        .plot_count (plot_count),
        .drop_count (drop_count),
        .oob_count  (oob_count)
    );

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } cmd_t;

    typedef struct {
        int x;
        int y;
        int c;
        int rx;
        int ry;
        int exp_rd;
        int exp_plot;
        int exp_oob;
    } vec_t;

    // Reference model state
    int   fb [19200];
    cmd_t q [$];
    int   m_plot, m_drop, m_oob;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " clear_busy"}, 32'(clear_busy), 0);
        check({tag, " rd_valid"}, 32'(rd_valid), 0);
        check({tag, " rd_colour"}, 32'(rd_colour), 0);
        check({tag, " plot_ready"}, 32'(plot_ready), 1);
        check({tag, " plot_count"}, 32'(plot_count), 0);
        check({tag, " drop_count"}, 32'(drop_count), 0);
        check({tag, " oob_count"}, 32'(oob_count), 0);
    endtask

    task automatic plot1(input int x, input int y, input int c);
        vga_plot   = 1'b1;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        tick();
        vga_plot   = 1'b0;
    endtask

    task automatic read1(input string name, input int x, input int y, input int exp);
        rd_en = 1'b1;
        rd_x  = 8'(x);
        rd_y  = 7'(y);
        tick();
        rd_en = 1'b0;
        check({name, " rd_valid"}, 32'(rd_valid), 1);
        check({name, " rd_colour"}, 32'(rd_colour), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        int   busy_cycles;
        int   guard;

        tbl[0] = '{160, 0,   1, 159, 0,   0, 9,  1};
        tbl[1] = '{0,   120, 2, 0,   119, 0, 9,  2};
        tbl[2] = '{159, 119, 6, 159, 119, 6, 10, 2};
        tbl[3] = '{255, 127, 7, 255, 127, 0, 10, 3};
        tbl[4] = '{0,   0,   4, 0,   0,   4, 11, 3};
        tbl[5] = '{159, 120, 3, 159, 119, 6, 11, 4};

        #23;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Put non-zero state everywhere, then reset in the middle of a clear
        plot1(5, 5, 1);
        tick();
        check("pre plot_count", 32'(plot_count), 1);
        plot1(200, 3, 1);
        check("pre oob_count", 32'(oob_count), 1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("abort clear_busy", 32'(clear_busy), 1);
        for (int i = 0; i < 10; i++) plot1(i, 0, 2);
        check("abort drop_count", 32'(drop_count), 2);
        repeat (4988) tick();
        rd_en = 1'b1;
        rd_x  = 8'd1;
        rd_y  = 7'd1;
        tick();
        rd_en = 1'b0;
        check("abort rd_valid", 32'(rd_valid), 1);
        check("abort still busy", 32'(clear_busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full clear with plots queued behind it
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        busy_cycles = clear_busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("clr plot_ready %0d", i), 32'(plot_ready), (i < 8) ? 1 : 0);
            clear_start = (i == 5);
            plot1(3 * i + 1, 2 * i + 1, (i % 7) + 1);
            if (clear_busy) busy_cycles++;
        end
        clear_start = 1'b0;
        check("clr drop_count", 32'(drop_count), 2);
        check("clr plot_ready full", 32'(plot_ready), 0);
        check("clr plot_count held", 32'(plot_count), 0);
        guard = 0;
        while (clear_busy && guard < 25000) begin
            tick();
            if (clear_busy) busy_cycles++;
            guard++;
        end
        check("clr busy cycles", 32'(busy_cycles), 19200);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("drain plot_count %0d", k), 32'(plot_count), 32'(k));
        end
        check("drain plot_ready", 32'(plot_ready), 1);

        foreach (fb[i]) fb[i] = 0;
        read1("rd 0,0", 0, 0, 0);
        tick();
        check("rd held one cycle", 32'(rd_valid), 0);
        read1("rd 159,119", 159, 119, 0);
        read1("rd 80,60", 80, 60, 0);
        for (int i = 0; i < 8; i++) begin
            read1($sformatf("rd queued %0d", i), 3 * i + 1, 2 * i + 1, (i % 7) + 1);
            fb[(2 * i + 1) * 160 + 3 * i + 1] = (i % 7) + 1;
        end
        read1("rd dropped", 25, 17, 0);

        // Read-before-write on the commit edge
        plot1(10, 20, 5);
        rd_en = 1'b1;
        rd_x  = 8'd10;
        rd_y  = 7'd20;
        tick();
        check("rbw valid", 32'(rd_valid), 1);
        check("rbw old data", 32'(rd_colour), 0);
        tick();
        rd_en = 1'b0;
        check("rbw new data", 32'(rd_colour), 5);
        check("rbw plot_count", 32'(plot_count), 9);
        fb[20 * 160 + 10] = 5;

        foreach (tbl[i]) begin
            plot1(tbl[i].x, tbl[i].y, tbl[i].c);
            tick();
            read1($sformatf("vec%0d", i), tbl[i].rx, tbl[i].ry, tbl[i].exp_rd);
            check($sformatf("vec%0d plot_count", i), 32'(plot_count), 32'(tbl[i].exp_plot));
            check($sformatf("vec%0d oob_count", i), 32'(oob_count), 32'(tbl[i].exp_oob));
            if (tbl[i].x < 160 && tbl[i].y < 120) fb[tbl[i].y * 160 + tbl[i].x] = tbl[i].c;
        end

        // Long random run: saturates plot_count and oob_count
        m_plot = 11;
        m_drop = 2;
        m_oob  = 4;
        for (int cyc = 0; cyc < 68000; cyc++) begin
            int   pl, oob, px, py, pc, re, rx, ry, pre, exp_c;
            cmd_t h;
            pl  = ($urandom_range(0, 127) != 0) ? 1 : 0;
            oob = ($urandom_range(0, 63) == 0) ? 1 : 0;
            pc  = $urandom_range(0, 7);
            if (!oob) begin
                px = $urandom_range(0, 159);
                py = $urandom_range(0, 119);
            end else if ($urandom_range(0, 1) == 1) begin
                px = $urandom_range(160, 255);
                py = $urandom_range(0, 127);
            end else begin
                px = $urandom_range(0, 159);
                py = $urandom_range(120, 127);
            end
            re = $urandom_range(0, 1);
            rx = $urandom_range(0, 175);
            ry = $urandom_range(0, 127);
            vga_plot   = pl[0];
            vga_x      = 8'(px);
            vga_y      = 7'(py);
            vga_colour = 3'(pc);
            rd_en      = re[0];
            rd_x       = 8'(rx);
            rd_y       = 7'(ry);
            tick();

            if (re != 0) begin
                exp_c = (rx < 160 && ry < 120) ? fb[ry * 160 + rx] : 0;
                check("rnd rd_valid", 32'(rd_valid), 1);
                check("rnd rd_colour", 32'(rd_colour), 32'(exp_c));
            end else begin
                check("rnd rd_valid idle", 32'(rd_valid), 0);
            end
            pre = q.size();
            if (pre > 0) begin
                h = q.pop_front();
                fb[h.y * 160 + h.x] = h.c;
                if (m_plot < 65535) m_plot++;
            end
            if (pl != 0) begin
                if (px >= 160 || py >= 120) begin
                    if (m_oob < 255) m_oob++;
                end else if (pre == 8) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    q.push_back('{px, py, pc});
                end
            end
            check("rnd plot_count", 32'(plot_count), 32'(m_plot));
            check("rnd oob_count", 32'(oob_count), 32'(m_oob));
            check("rnd drop_count", 32'(drop_count), 32'(m_drop));
            check("rnd plot_ready", 32'(plot_ready), (q.size() < 8) ? 1 : 0);
        end
        vga_plot = 1'b0;
        rd_en    = 1'b0;
        check("sat plot_count", 32'(plot_count), 65535);
        check("sat oob_count", 32'(oob_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_pixel_sink.md
Name: vga_pixel_sink

Overview:
Consumer end of the VGA plot interface driven by the drawing FSMs (fill, circle, Reuleaux). It accepts (x, y, colour, plot) commands, bounds-checks them, buffers them in a small FIFO and commits them to a 160x120x3 framebuffer RAM. It also provides a registered readback port and a bulk-clear engine. It is used as a scoreboard-grade pixel store in place of the VGA adapter, in simulation and in on-board self-check builds.

Parameters:
FIFO_DEPTH, 8, command FIFO entries (power of 2, >=2)
SCREEN_W, 160, framebuffer width in pixels
SCREEN_H, 120, framebuffer height in pixels

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
rst_n  in  1  asynchronous active-low reset
vga_x  in  8  plot x coordinate
vga_y  in  7  plot y coordinate
vga_colour  in  3  plot colour
vga_plot  in  1  plot strobe, one command per high cycle
plot_ready  out  1  high when FIFO not full
clear_start  in  1  one-cycle pulse, begins framebuffer clear
clear_busy  out  1  high while clear in progress
rd_en  in  1  readback request
rd_x  in  8  readback x
rd_y  in  7  readback y
rd_colour  out  3  readback data
rd_valid  out  1  readback data valid
plot_count  out  16  pixels committed to RAM (saturating)
drop_count  out  8  plots lost to full FIFO (saturating)
oob_count  out  8  plots rejected for x>=SCREEN_W or y>=SCREEN_H (saturating)

Behaviour:
- Reset (async, rst_n=0): FIFO empty, FSM=RUN, plot_ready=1, clear_busy=0, rd_valid=0, rd_colour=0, all counters 0. RAM contents not reset (undefined until cleared). Reset mid-clear aborts the clear immediately.
- Address = y*SCREEN_W + x, 15 bits, computed as (y<<7)+(y<<5)+x for defaults; no multiplier.
- Accept, sampled at each rising edge with vga_plot=1:
  - Out of bounds: oob_count++; not queued. Bounds check takes priority over the full check.
  - In bounds and FIFO full: drop_count++; not queued.
  - Otherwise: push {x,y,colour}.
- A push and a pop in the same cycle on a full FIFO is still a drop; plot_ready reflects state before the edge.
- FSM states:
  - RUN: pops one FIFO entry per cycle when non-empty, writes RAM, plot_count++. clear_start=1 -> CLEAR, clr_addr=0.
  - CLEAR: writes colour 0 at clr_addr each cycle, clr_addr++. At clr_addr=SCREEN_W*SCREEN_H-1, writes and returns to RUN. Duration exactly 19200 cycles.
  - clear_busy=1 for exactly those cycles. clear_start is ignored in CLEAR.
  - The FIFO does not drain during CLEAR; plots still enqueue until full, then drop.
- Latency: a plot sampled at edge N into an empty FIFO in RUN is written to RAM at edge N+1.
- Readback: rd_en sampled at edge k -> rd_colour/rd_valid valid after edge k, held one cycle. rd_valid=0 otherwise.
  - Read-before-write: a read and a write to the same address at the same edge returns the old data.
  - Out-of-bounds reads return 0 with rd_valid=1.
- Counters saturate at all-ones, never wrap.

Decomposition:
- Package vga_pkg: SCREEN_W/SCREEN_H localparams, FB_DEPTH=19200, typedef colour_t (3b), xcoord_t (8b), ycoord_t (7b), fbaddr_t (15b), packed struct pixel_cmd_t {x,y,colour}, enum sink_state_t {RUN, CLEAR}.
- Sub-module plot_fifo: parameterised synchronous FIFO of pixel_cmd_t with push/pop/full/empty, async active-low reset.
- Framebuffer RAM is inferred inline (simple dual-port: one write, one registered read).

Test Plan:
1. Reset, clear_start pulse -> clear_busy high exactly 19200 cycles. Then rd (0,0), (159,119), (80,60) all return colour 0 with rd_valid=1 one cycle after rd_en.
2. After clear, plot (10,20,colour 5) at edge N -> rd at edge N+1 returns 0 (read-before-write), rd at edge N+2 returns 5, plot_count=1.
3. Plots (160,0,1) and (0,120,2) -> oob_count=2, plot_count unchanged, RAM at (159,0) and (0,119) still 0.
4. Start clear, then issue 10 consecutive in-bounds plots -> first 8 queued, plot_ready low after 8th, drop_count=2. After clear ends, 8 pixels committed over 8 cycles, plot_count=8, colours readable.
5. Assert rst_n=0 mid-clear (cycle 5000) -> clear_busy, rd_valid and all counters 0 and plot_ready=1 immediately, without waiting for a clock edge. A new clear after release completes in 19200 cycles.
6. Issue 70000 valid plots with FIFO draining -> plot_count saturates at 65535.
